// File: rtl/accel_reg_pkg.sv
// rtl/accel_reg_pkg.sv - shared word/kernel constants and count-width helper
package accel_reg_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int KERNEL_MAX = 16;

  typedef logic [WORD_WIDTH-1:0] word_t;

  // Bits needed to hold a fill level of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one enable-gated chain register (SHIFT_CHAIN_PLOAD_EN adds parallel load)
module shift_stage #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
`ifdef SHIFT_CHAIN_PLOAD_EN
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_pd,
`endif
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Stage register: reset and flush clear it, load overrides shift, otherwise hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
`ifdef SHIFT_CHAIN_PLOAD_EN
    end else if (i_load) begin
      r_q <= i_pd;
`endif
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/register_shift_chain.sv
// rtl/register_shift_chain.sv - DEPTH-stage tapped shift chain with fill count (SHIFT_CHAIN_PLOAD_EN adds LOAD/Pin)
module register_shift_chain
  import accel_reg_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = 5,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   EN,
  input  logic                   CLR,
  input  logic [WIDTH-1:0]       Din,
`ifdef SHIFT_CHAIN_PLOAD_EN
  input  logic                   LOAD,
  input  logic [DEPTH*WIDTH-1:0] Pin,
`endif
  output logic [WIDTH-1:0]       Dout,
  output logic [DEPTH*WIDTH-1:0] Taps,
  output logic [CNT_W-1:0]       Count,
  output logic                   Full
);

  localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(DEPTH);

  logic [WIDTH-1:0] w_stage_q [DEPTH];
  logic [CNT_W-1:0] r_count;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] w_d;

    if (g == 0) begin : g_head
      assign w_d = Din;
    end else begin : g_link
      assign w_d = w_stage_q[g-1];
    end

    shift_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .i_clk  (CLK),
      .i_rst  (RST),
      .i_clr  (CLR),
      .i_en   (EN),
      .i_d    (w_d),
`ifdef SHIFT_CHAIN_PLOAD_EN
      .i_load (LOAD),
      .i_pd   (Pin[g*WIDTH +: WIDTH]),
`endif
      .o_q    (w_stage_q[g])
    );

    assign Taps[g*WIDTH +: WIDTH] = w_stage_q[g];
  end

  // Fill level: counts enabled shifts, saturating at DEPTH; load marks the chain full.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count <= '0;
    end else if (CLR) begin
      r_count <= '0;
`ifdef SHIFT_CHAIN_PLOAD_EN
    end else if (LOAD) begin
      r_count <= LP_DEPTH;
`endif
    end else if (EN && (r_count != LP_DEPTH)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign Dout  = w_stage_q[DEPTH-1];
  assign Count = r_count;
  assign Full  = (r_count == LP_DEPTH);

endmodule
